jtag_wb_arbiter: RTL and testbench



---
 rtl/jtag_wb_arbiter_if.sv | 22 ++
 rtl/jtag_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_jtag_wb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_wb_arbiter_if.sv
// Pipelined Wishbone bus between the JTAG arbiter (master) and the debug register slave.
interface jtag_wb_arbiter_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_stall_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_stall_i
  );
endinterface

// File: rtl/jtag_wb_arbiter.sv
// Round-robin arbiter sharing the LM32 JTAG-over-Wishbone register slave between two debug hosts.
// Optional ack timeout enabled by defining JTAG_WB_ARB_TIMEOUT_EN.
module jtag_wb_arbiter #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic        req0_we_i,
  input  logic [2:0]  req0_addr_i,
  input  logic [7:0]  req0_data_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic        req1_we_i,
  input  logic [2:0]  req1_addr_i,
  input  logic [7:0]  req1_data_i,
  output logic        rsp0_valid_o,
  output logic [10:0] rsp0_data_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  output logic [10:0] rsp1_data_o,
  output logic        rsp1_err_o,
  output logic [1:0]  state_dbg_o,
  jtag_wb_arbiter_if.master wb
);

  // Handshake: a command transfers in the cycle where reqN_valid_i and reqN_ready_o are
  // both high; ready is a single-cycle pulse given only in IDLE, valid may be withdrawn at
  // any time before that. rspN_valid_o is a single-cycle pulse with no backpressure.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, grant_q, we_q, err_q;
  logic [2:0]  addr_q;
  logic [7:0]  data_q;
  logic [10:0] rsp0_data_q, rsp1_data_q;
  logic        gnt_any, gnt_idx, in_bus, ack_take, tmo_hit;
  logic        unused_dat;

  assign gnt_any  = req0_valid_i | req1_valid_i;
  assign gnt_idx  = (req0_valid_i & req1_valid_i) ? ~last_grant_q : req1_valid_i;
  assign in_bus   = (state_q == STROBE) || (state_q == WAIT_ACK);
  assign ack_take = (state_q == WAIT_ACK) && wb.wb_ack_i;

`ifdef JTAG_WB_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // Counts cycles since the strobe was first driven; zero whenever the bus is idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (!in_bus) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  assign tmo_hit = in_bus && (tmo_cnt_q == (TIMEOUT_CYCLES - 32'd1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    wb.wb_cyc_o  = 1'b0;
    wb.wb_stb_o  = 1'b0;
    wb.wb_we_o   = 1'b0;
    wb.wb_dat_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d      = STROBE;
          req0_ready_o = ~gnt_idx;
          req1_ready_o = gnt_idx;
        end
      end
      STROBE: begin
        wb.wb_cyc_o = 1'b1;
        wb.wb_stb_o = 1'b1;
        wb.wb_we_o  = we_q;
        wb.wb_dat_o = {21'h0, data_q, addr_q};
        if (tmo_hit) begin
          state_d = RESP;
        end else if (!wb.wb_stall_i) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        wb.wb_cyc_o = 1'b1;
        wb.wb_we_o  = we_q;
        wb.wb_dat_o = {21'h0, data_q, addr_q};
        if (wb.wb_ack_i || tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp0_valid_o = ~grant_q;
        rsp1_valid_o = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_any) begin
        grant_q      <= gnt_idx;
        last_grant_q <= gnt_idx;
        we_q         <= gnt_idx ? req1_we_i   : req0_we_i;
        addr_q       <= gnt_idx ? req1_addr_i : req0_addr_i;
        data_q       <= gnt_idx ? req1_data_i : req0_data_i;
      end
      // An ack on the timeout edge wins; a timeout alone returns zero data with the error flag.
      if (ack_take || tmo_hit) begin
        err_q <= ~ack_take;
        if (grant_q) begin
          rsp1_data_q <= ack_take ? wb.wb_dat_i[10:0] : 11'h0;
        end else begin
          rsp0_data_q <= ack_take ? wb.wb_dat_i[10:0] : 11'h0;
        end
      end
    end
  end

  assign rsp0_data_o = rsp0_data_q;
  assign rsp1_data_o = rsp1_data_q;
  assign rsp0_err_o  = rsp0_valid_o & err_q;
  assign rsp1_err_o  = rsp1_valid_o & err_q;
  assign state_dbg_o = state_q;
  assign wb.wb_adr_o = BASE_ADDR;
  assign wb.wb_sel_o = 4'hF;
  assign unused_dat  = ^wb.wb_dat_i[31:11];

endmodule

// File: tb/tb_jtag_wb_arbiter.sv
// Self-checking bench for jtag_wb_arbiter: directed vector table, reset/contention sequences
// and randomized traffic against a transaction-level reference model.
module tb_jtag_wb_arbiter;
  localparam int TMO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid_i = 1'b0, req0_we_i = 1'b0, req1_valid_i = 1'b0, req1_we_i = 1'b0;
  logic [2:0]  req0_addr_i = '0, req1_addr_i = '0;
  logic [7:0]  req0_data_i = '0, req1_data_i = '0;
  logic        req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_err_o, rsp1_err_o;
  logic [10:0] rsp0_data_o, rsp1_data_o;
  logic [1:0]  state_dbg_o;

  jtag_wb_arbiter_if bus ();

  jtag_wb_arbiter #(.BASE_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o), .rsp0_err_o(rsp0_err_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o), .rsp1_err_o(rsp1_err_o),
    .state_dbg_o(state_dbg_o), .wb(bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Slave model: reflects the last written {data, addr}, acks ack_wait cycles after the
  // accepted strobe, stalls for stall_cfg cycles of each command.
  int          ack_cnt, stall_cnt;
  int          stall_cfg = 0;
  int          ack_wait  = 8;
  bit          no_ack    = 1'b0;
  logic [10:0] reg_val;
  logic [31:0] junk;
  logic        slv_ack;

  assign slv_ack        = (ack_cnt == 1) && !no_ack;
  assign bus.wb_ack_i   = slv_ack;
  assign bus.wb_stall_i = (stall_cnt != 0);
  assign bus.wb_dat_i   = slv_ack ? {junk[31:11], reg_val} : junk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt <= 0; stall_cnt <= 0; reg_val <= '0; junk <= '0;
    end else begin
      junk <= $urandom;
      if (req0_ready_o || req1_ready_o) stall_cnt <= stall_cfg;
      else if (bus.wb_stb_o && stall_cnt != 0) stall_cnt <= stall_cnt - 1;
      if (bus.wb_stb_o && !bus.wb_stall_i) begin
        ack_cnt <= ack_wait + 1;
        if (bus.wb_we_o) reg_val <= bus.wb_dat_o[10:0];
      end else if (ack_cnt != 0) begin
        ack_cnt <= ack_cnt - 1;
      end
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model and scoreboard, evaluated mid-cycle.
  logic [11:0] exp_q[$];
  bit          model_busy = 1'b0, model_last = 1'b1, exp_err, exp_we, first_we;
  logic [10:0] model_reg = '0;
  logic [10:0] held [2];
  int          acc_cyc, exp_lat, exp_stb, stb_n;
  logic [31:0] exp_dat, first_dat;
  int          rsp_cnt [2];
  bit          grant_log[$];
  bit          last_port, last_err;
  logic [10:0] last_data;
  int          last_lat, last_stb;
  logic [31:0] last_dat;
  logic        gp, idle_exp, we_a;
  logic [2:0]  addr_a;
  logic [7:0]  data_a;
  logic [11:0] e, got;

  initial begin
    held[0] = '0; held[1] = '0; rsp_cnt[0] = 0; rsp_cnt[1] = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); model_busy = 1'b0; model_last = 1'b1; model_reg = '0;
      held[0] = '0; held[1] = '0; stb_n = 0;
    end else begin
      if (bus.wb_stb_o) begin
        if (stb_n == 0) begin first_dat = bus.wb_dat_o; first_we = bus.wb_we_o; end
        else check("stb_dat_stable", bus.wb_dat_o, first_dat);
        stb_n++;
      end
      idle_exp = !model_busy && (req0_valid_i || req1_valid_i);
      if (req0_ready_o || req1_ready_o || idle_exp) begin
        check("grant_present", 32'(req0_ready_o | req1_ready_o), 32'(idle_exp));
        if (req0_ready_o || req1_ready_o) begin
          gp = (req0_valid_i && req1_valid_i) ? !model_last : req1_valid_i;
          check("ready_onehot", 32'(req0_ready_o & req1_ready_o), 32'd0);
          check("grant_port", 32'(req1_ready_o), 32'(gp));
          we_a   = gp ? req1_we_i : req0_we_i;
          addr_a = gp ? req1_addr_i : req0_addr_i;
          data_a = gp ? req1_data_i : req0_data_i;
          if (we_a) model_reg = {data_a, addr_a};
          exp_q.push_back({gp, no_ack ? 11'h0 : model_reg});
          exp_err = no_ack; exp_we = we_a; exp_dat = {21'h0, data_a, addr_a};
          exp_lat = no_ack ? TMO + 1 : 3 + stall_cfg + ack_wait;
          exp_stb = stall_cfg + 1;
          acc_cyc = cyc_n; stb_n = 0;
          model_last = gp; model_busy = 1'b1;
          grant_log.push_back(gp);
        end
      end
      if (rsp0_valid_o || rsp1_valid_o) begin
        check("rsp_onehot", 32'(rsp0_valid_o & rsp1_valid_o), 32'd0);
        check("rsp_outstanding", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          got = rsp1_valid_o ? {1'b1, rsp1_data_o} : {1'b0, rsp0_data_o};
          check("rsp_port_data", 32'(got), 32'(e));
          check("rsp_err", 32'(rsp1_valid_o ? rsp1_err_o : rsp0_err_o), 32'(exp_err));
          check("rsp_latency", cyc_n - acc_cyc, exp_lat);
          check("stb_cycles", stb_n, exp_stb);
          check("stb_dat", first_dat, exp_dat);
          check("stb_we", 32'(first_we), 32'(exp_we));
          check("other_port_held", 32'(rsp1_valid_o ? rsp0_data_o : rsp1_data_o),
                32'(held[!rsp1_valid_o]));
          held[rsp1_valid_o] = got[10:0];
          last_port = rsp1_valid_o; last_data = got[10:0];
          last_err = rsp1_valid_o ? rsp1_err_o : rsp0_err_o;
          last_lat = cyc_n - acc_cyc; last_stb = stb_n; last_dat = first_dat;
        end
        rsp_cnt[rsp1_valid_o]++;
        model_busy = 1'b0;
      end
    end
  end

  // Driver
  bit a0, a1;

  task automatic step();
    @(negedge clk);
    a0 = req0_ready_o; a1 = req1_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(bit p, bit v, bit we, logic [2:0] addr, logic [7:0] data);
    if (p) begin req1_valid_i = v; req1_we_i = we; req1_addr_i = addr; req1_data_i = data; end
    else   begin req0_valid_i = v; req0_we_i = we; req0_addr_i = addr; req0_data_i = data; end
  endtask

  function automatic int rsp_total();
    return rsp_cnt[0] + rsp_cnt[1];
  endfunction

  task automatic drain(string name);
    int n = 0;
    while (model_busy && n < 200) begin step(); n++; end
    check(name, 32'(model_busy), 32'd0);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [2:0]  addr;
    logic [7:0]  data;
    int          stall;
    int          ackw;
    logic [31:0] exp_dat;
    logic [10:0] exp_rsp;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  task automatic run_vec(vec_t v);
    int base, other, n;
    base = rsp_total(); other = rsp_cnt[!v.port];
    stall_cfg = v.stall; ack_wait = v.ackw;
    set_req(v.port, 1'b1, v.we, v.addr, v.data);
    n = 0;
    do begin step(); n++; end while (!(v.port ? a1 : a0) && n < 20);
    check("vec_accept", 32'(v.port ? a1 : a0), 32'd1);
    set_req(v.port, 1'b0, 1'b0, 3'h0, 8'h00);
    n = 0;
    while (rsp_total() == base && n < 200) begin step(); n++; end
    check("vec_rsp_count", rsp_total() - base, 1);
    check("vec_rsp_port", 32'(last_port), 32'(v.port));
    check("vec_rsp_data", 32'(last_data), 32'(v.exp_rsp));
    check("vec_rsp_err", 32'(last_err), 32'(v.exp_err));
    check("vec_latency", last_lat, v.exp_lat);
    check("vec_stb_cycles", last_stb, v.stall + 1);
    check("vec_wb_dat", last_dat, v.exp_dat);
    check("vec_other_silent", rsp_cnt[!v.port], other);
  endtask

  task automatic rand_port(bit p, bit acc);
    bit cur;
    cur = p ? req1_valid_i : req0_valid_i;
    if (cur && acc) begin
      if ($urandom_range(0, 1) == 1)
        set_req(p, 1'b1, 1'($urandom), 3'($urandom), 8'($urandom));
      else set_req(p, 1'b0, 1'b0, 3'h0, 8'h00);
    end else if (cur && $urandom_range(0, 9) == 0) begin
      set_req(p, 1'b0, 1'b0, 3'h0, 8'h00);
    end else if (!cur && $urandom_range(0, 2) == 0) begin
      set_req(p, 1'b1, 1'($urandom), 3'($urandom), 8'($urandom));
    end
  endtask

  vec_t vecs [5];

  initial begin
    int n, base;
    vecs[0] = '{1'b0, 1'b1, 3'h5, 8'hA7, 0, 8, 32'h0000_053D, 11'h53D, 11, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 3'h2, 8'h3C, 0, 2, 32'h0000_01E2, 11'h1E2, 5, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 3'h7, 8'hFF, 0, 8, 32'h0000_07FF, 11'h1E2, 11, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 3'h1, 8'h55, 5, 3, 32'h0000_02A9, 11'h2A9, 11, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 3'h0, 8'h00, 0, 0, 32'h0000_0000, 11'h2A9, 3, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    check("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    check("rst_we", 32'(bus.wb_we_o), 32'd0);
    check("rst_adr", bus.wb_adr_o, 32'h0000_0000);
    check("rst_sel", 32'(bus.wb_sel_o), 32'hF);
    check("rst_dat", bus.wb_dat_o, 32'h0);
    check("rst_rsp_valid", 32'({rsp0_valid_o, rsp1_valid_o}), 32'd0);
    check("rst_rsp_data", 32'({rsp0_data_o, rsp1_data_o}), 32'd0);
    check("rst_rsp_err", 32'({rsp0_err_o, rsp1_err_o}), 32'd0);
    check("rst_state", 32'(state_dbg_o), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset while waiting for ack: bus drops immediately, command is lost.
    stall_cfg = 0; ack_wait = 8;
    set_req(1'b1, 1'b1, 1'b1, 3'h4, 8'h11);
    n = 0;
    do begin step(); n++; end while (!a1 && n < 20);
    set_req(1'b1, 1'b0, 1'b0, 3'h0, 8'h00);
    repeat (3) step();
    check("pre_rst_cyc", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'b10);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cyc_stb", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
    base = rsp_total();
    step(); step();
    rst = 1'b0;
    repeat (15) step();
    check("rst_no_rsp", rsp_total() - base, 0);

    // Continuous contention right after reset: port 0 first, then strict alternation.
    stall_cfg = 0; ack_wait = 1;
    grant_log.delete();
    set_req(1'b0, 1'b1, 1'b0, 3'h1, 8'h10);
    set_req(1'b1, 1'b1, 1'b0, 3'h2, 8'h20);
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin step(); n++; end
    set_req(1'b0, 1'b0, 1'b0, 3'h0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 3'h0, 8'h00);
    check("contend_grants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("contend_order", 32'(grant_log[i]), 32'(i % 2));
    drain("contend_drain");

    // Randomized traffic
    for (int blk = 0; blk < 4; blk++) begin
      stall_cfg = $urandom_range(0, 3);
      ack_wait  = $urandom_range(0, 6);
      for (int c = 0; c < 80; c++) begin
        step();
        rand_port(1'b0, a0);
        rand_port(1'b1, a1);
      end
      set_req(1'b0, 1'b0, 1'b0, 3'h0, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 3'h0, 8'h00);
      drain("rand_drain");
    end

`ifdef JTAG_WB_ARB_TIMEOUT_EN
    no_ack = 1'b1;
    run_vec('{1'b0, 1'b1, 3'h3, 8'h81, 0, 8, 32'h0000_040B, 11'h000, TMO + 1, 1'b1});
    no_ack = 1'b0;
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
